// File: rtl/trivium_out_fifo.sv
// Byte FIFO between the Trivium core and the host: buffers ciphertext,
// reports fill status to the core on fifo_cnd, and flushes on core key error or total reset.
module trivium_out_fifo #(
    parameter int DEPTH     = 256,
    parameter int AW        = 8,
    parameter int AFULL_LVL = 240
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    stream,
    input  logic          wt_sgn,
    input  logic [7:0]    sign_reg,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [1:0]    fifo_cnd,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_AFULL   = 2'b10,
        ST_FULL    = 2'b11
    } cnd_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_d;
    cnd_t          cnd_q;
    cnd_t          cnd_d;
    logic          full;
    logic          empty;
    logic          flush;
    logic          wr_acc;
    logic          rd_acc;

    // Full/empty come from the registered level, so a same-cycle read never frees room for a write.
    assign full   = (level == LVL_FULL);
    assign empty  = (level == '0);
    assign flush  = sign_reg[3] | sign_reg[4];
    assign wr_acc = wt_sgn & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (wr_acc && !rd_acc) begin
            level_d = level + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_d = level - LVL_ONE;
        end
    end

    // Status follows the next level; every 2-bit encoding maps back to a level-derived state.
    always_comb begin
        cnd_d = ST_EMPTY;
        if (level_d == LVL_FULL) begin
            cnd_d = ST_FULL;
        end else if (level_d >= LVL_AFULL) begin
            cnd_d = ST_AFULL;
        end else if (level_d != '0) begin
            cnd_d = ST_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= stream;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
            cnd_q    <= ST_EMPTY;
        end else begin
            level    <= level_d;
            cnd_q    <= cnd_d;
            rd_valid <= rd_acc;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_acc) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    rd_data <= mem[rd_ptr];
                end
                if (wt_sgn && full) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign fifo_cnd = cnd_q;

endmodule

// File: tb/tb_trivium_out_fifo.sv
// Directed bench for trivium_out_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_trivium_out_fifo;

    localparam int DEPTH     = 256;
    localparam int AW        = 8;
    localparam int AFULL_LVL = 240;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    stream;
    logic          wt_sgn;
    logic [7:0]    sign_reg;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [1:0]    fifo_cnd;
    logic [AW:0]   level;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;

    trivium_out_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFULL_LVL)) dut (
        .clk      (clk),
        .rst      (rst),
        .stream   (stream),
        .wt_sgn   (wt_sgn),
        .sign_reg (sign_reg),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .fifo_cnd (fifo_cnd),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the few visible registers.
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_valid;
    logic       m_ovf;
    logic       m_live = 1'b0;

    function automatic logic [1:0] cnd_of(int n);
        if (n == 0) return 2'b00;
        if (n == DEPTH) return 2'b11;
        if (n >= AFULL_LVL) return 2'b10;
        return 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int n;
        n = q.size();
        if (rst) begin
            q.delete();
            m_rd_data  = 8'h00;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_live     = 1'b1;
        end else if (sign_reg[3] || sign_reg[4]) begin
            q.delete();
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            m_rd_valid = 1'b0;
            if (rd_en && n > 0) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (wt_sgn) begin
                if (n == DEPTH) m_ovf = 1'b1;
                else q.push_back(stream);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_level", 32'(level), 32'(q.size()));
            check("model_cnd", 32'(fifo_cnd), 32'(cnd_of(q.size())));
            check("model_ovf", 32'(ovf), 32'(m_ovf));
            check("model_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("model_rd_data", 32'(rd_data), 32'(m_rd_data));
        end
    end

    task automatic step(input logic w, input logic [7:0] s, input logic r,
                        input logic [7:0] sg, input logic rs);
        wt_sgn   = w;
        stream   = s;
        rd_en    = r;
        sign_reg = sg;
        rst      = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_to_37_with_ovf();
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 219; i++) step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("t5_pre_level", 32'(level), 32'd37);
        check("t5_pre_ovf", 32'(ovf), 32'd1);
        check("t5_pre_rd_data", 32'(rd_data), 32'hDA);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("reset_level", 32'(level), 32'd0);
        check("reset_cnd", 32'(fifo_cnd), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);

        // 1: full burst of 256 bytes
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
            if (i == 238) check("t1_cnd_at_239", 32'(fifo_cnd), 32'b01);
            if (i == 239) check("t1_cnd_at_240", 32'(fifo_cnd), 32'b10);
            if (i == 254) check("t1_cnd_at_255", 32'(fifo_cnd), 32'b10);
        end
        check("t1_level", 32'(level), 32'd256);
        check("t1_cnd", 32'(fifo_cnd), 32'b11);
        check("t1_ovf", 32'(ovf), 32'd0);

        // 2: overflow while full, then drain in order
        step(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        check("t2_level", 32'(level), 32'd256);
        check("t2_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
            check("t2_rd_valid", 32'(rd_valid), 32'd1);
            check("t2_rd_data", 32'(rd_data), 32'(i));
        end
        check("t2_cnd", 32'(fifo_cnd), 32'b00);
        check("t2_ovf_sticky", 32'(ovf), 32'd1);

        step(1'b0, 8'h00, 1'b0, 8'h08, 1'b0);
        check("flush_clears_ovf", 32'(ovf), 32'd0);

        // 3: steady state at level 100, then empty reads
        for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'(100 + i), 1'b1, 8'h00, 1'b0);
            check("t3_rw_data", 32'(rd_data), 32'(i));
        end
        check("t3_level", 32'(level), 32'd100);
        check("t3_cnd", 32'(fifo_cnd), 32'b01);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
            check("t3_drain_data", 32'(rd_data), 32'(50 + i));
        end
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("t3_empty_rd_valid", 32'(rd_valid), 32'd0);
        check("t3_empty_rd_data", 32'(rd_data), 32'h95);
        step(1'b1, 8'h77, 1'b1, 8'h00, 1'b0);
        check("t3_no_fallthru_valid", 32'(rd_valid), 32'd0);
        check("t3_no_fallthru_data", 32'(rd_data), 32'h95);
        check("t3_no_fallthru_level", 32'(level), 32'd1);
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("t3_late_read", 32'(rd_data), 32'h77);

        // 4: 300 bytes across pointer wrap
        for (int k = 0; k < 150; k++) step(1'b1, 8'(k), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 150; i++) begin
            step(1'b1, 8'(150 + i), 1'b1, 8'h00, 1'b0);
            check("t4_rw_data", 32'(rd_data), 32'(i & 255));
        end
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
            check("t4_drain_data", 32'(rd_data), 32'((150 + i) & 255));
        end
        check("t4_level", 32'(level), 32'd0);
        check("t4_ovf", 32'(ovf), 32'd0);
        check("t4_last", 32'(rd_data), 32'h2B);

        // 5: flush beats simultaneous write and read
        fill_to_37_with_ovf();
        step(1'b1, 8'hEE, 1'b1, 8'h10, 1'b0);
        check("t5a_level", 32'(level), 32'd0);
        check("t5a_cnd", 32'(fifo_cnd), 32'b00);
        check("t5a_ovf", 32'(ovf), 32'd0);
        check("t5a_rd_valid", 32'(rd_valid), 32'd0);
        check("t5a_rd_data_hold", 32'(rd_data), 32'hDA);
        fill_to_37_with_ovf();
        step(1'b1, 8'hEE, 1'b1, 8'h08, 1'b0);
        check("t5b_level", 32'(level), 32'd0);
        check("t5b_cnd", 32'(fifo_cnd), 32'b00);
        check("t5b_ovf", 32'(ovf), 32'd0);
        check("t5b_rd_valid", 32'(rd_valid), 32'd0);

        // 6: reset mid-operation
        for (int i = 0; i < 180; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        check("t6_pre_level", 32'(level), 32'd180);
        step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        check("t6_level", 32'(level), 32'd0);
        check("t6_cnd", 32'(fifo_cnd), 32'b00);
        check("t6_rd_data", 32'(rd_data), 32'd0);
        check("t6_ovf", 32'(ovf), 32'd0);
        step(1'b1, 8'h5C, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("t6_rd_data_5c", 32'(rd_data), 32'h5C);
        check("t6_rd_valid", 32'(rd_valid), 32'd1);

        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trivium_out_fifo.md
Name: trivium_out_fifo

Overview:
Output buffer directly downstream of the Trivium cipher core. It captures each ciphertext byte presented on stream/wt_sgn and holds it until the host reads it. It reports its fill status back to the core on fifo_cnd; the core resumes keystream generation only when fifo_cnd==2'b00. It also flushes itself when the core's status register signals a key error or total reset.

Parameters:
DEPTH, 256, number of byte entries; must be a power of two, minimum 4.
AW, 8, pointer width; equals log2(DEPTH).
AFULL_LVL, 240, level at or above which the FIFO reports almost-full; valid range 1..DEPTH-1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-high.
stream  input  8  ciphertext byte from the cipher core.
wt_sgn  input  1  write strobe from the core; one byte per high cycle.
sign_reg  input  8  core status register; bit3 = key error, bit4 = total reset.
rd_en  input  1  host read request.
rd_data  output  8  byte read out; registered.
rd_valid  output  1  high for one cycle when rd_data carries a new byte.
fifo_cnd  output  2  fill status returned to the core.
level  output  AW+1  current number of stored bytes, 0..DEPTH.
ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst=1 at a rising edge) sets wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, ovf=0, fifo_cnd=2'b00. Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data on that edge. There is no partial drain.
- Storage is a DEPTH x 8 simple dual-port array. wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH with no special case.
- full means level==DEPTH; empty means level==0. Both are evaluated from the registered level at the start of the cycle.
- Write: if wt_sgn=1 and not full, then mem[wr_ptr]<=stream and wr_ptr increments.
- Overflow: if wt_sgn=1 and full, the byte is dropped and ovf<=1. This applies even when a read is accepted in the same cycle; there is no write-through on full.
- Read: if rd_en=1 and not empty, then rd_data<=mem[rd_ptr], rd_valid<=1 on that edge, and rd_ptr increments.
- Read latency: rd_en sampled at edge N yields rd_data/rd_valid valid after edge N. rd_valid is 0 in every other cycle.
- rd_en while empty is ignored: rd_valid=0 and rd_data holds its value. There is no fall-through, even if a write occurs in the same cycle.
- Simultaneous accepted write and read: level is unchanged and both pointers advance.
- Level update: level <= level + accepted_write - accepted_read, saturating only by construction.
- Flush condition: sign_reg[3] | sign_reg[4] sampled high at an edge.
  - Flush sets wr_ptr=0, rd_ptr=0, level=0, ovf=0, rd_valid=0.
  - Flush has priority over a write and a read in the same cycle; both are discarded.
  - rd_data holds its value during flush.
- fifo_cnd is registered and updated on the same edge as level, from the next level value:
  - 2'b00: empty.
  - 2'b01: 1 <= level < AFULL_LVL.
  - 2'b10: AFULL_LVL <= level < DEPTH.
  - 2'b11: full.
- fifo_cnd status state machine:
  - States are EMPTY(00), PARTIAL(01), AFULL(10), FULL(11).
  - Transitions follow the next level exactly, so multi-step jumps occur only on flush or reset (any state to EMPTY).
  - An illegal encoding recovers to the state derived from level on the next edge.
- ovf clears only on rst or flush. A read does not clear it.
- The cipher core produces 256 bytes and then waits for 2'b00. With DEPTH=256, a full burst exactly fills the FIFO without overflow.

Test Plan:
1. Reset, then 256 wt_sgn pulses with stream=0x00..0xFF -> level=256, fifo_cnd=11, ovf=0; fifo_cnd=10 from the cycle after the 240th write until the 256th write.
2. From full, one more wt_sgn with stream=0xAA -> level stays 256, ovf=1; after 256 reads the output sequence is 0x00..0xFF with no 0xAA, rd_valid each cycle one edge after rd_en, final fifo_cnd=00, ovf still 1.
3. At level=100, hold wt_sgn=1 and rd_en=1 for 50 cycles -> level stays 100, fifo_cnd=01; bytes read out in FIFO order; then rd_en on an empty FIFO -> rd_valid=0 and rd_data unchanged.
4. Write 300 bytes (counter pattern mod 256) interleaved with 300 reads, never exceeding 200 stored -> all 300 bytes read back in order across pointer wrap, ovf=0, level=0 at the end.
5. At level=37 with ovf=1, drive sign_reg=8'h10 together with wt_sgn=1 and rd_en=1 -> next edge level=0, fifo_cnd=00, ovf=0, rd_valid=0; repeat with sign_reg=8'h08 -> same result.
6. At level=180, assert rst for one cycle while writing -> level=0, fifo_cnd=00, rd_data=0, ovf=0; a subsequent write of 0x5C then a read -> rd_data=0x5C with rd_valid=1.
